uart_receiver: RTL
==================

# uart_receiver

Serial-to-parallel UART receive stage, the line-side counterpart of the team's `uart_transmitter`. It consumes the serial line that the transmitter drives: 8 data bits, LSB first, one start bit, one stop bit, no parity. It delivers each received byte through a valid/ready handshake. It uses 16x oversampling with mid-bit sampling and flags framing errors and overruns.

## Interface
- `CLOCK_FREQ`, 50_000_000: system clock frequency in Hz.
- `BAUD_RATE`, 9600: line bit rate in bits/s.
- `clk`  in  1  single system clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rx_pin`  in  1  asynchronous serial input; idles high.
- `rx_data`  out  8  last accepted byte.
- `rx_valid`  out  1  `rx_data` holds an unconsumed byte.
- `rx_ready`  in  1  consumer accepts `rx_data` when `rx_valid & rx_ready`.
- `rx_busy`  out  1  high whenever the FSM is not in IDLE.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `rx_overrun`  out  1  one-cycle pulse: new byte overwrote an unconsumed one.

## Operation
- **Synchronizer**
  - `rx_pin` passes through 2 flops to give `rx_sync`.
  - Both flops reset to 1.
  - All FSM decisions use `rx_sync` only.
- **Oversample tick**
  - DIV = CLOCK_FREQ / (BAUD_RATE*16), integer floor; DIV ≥ 1 is required.
  - A free-running counter counts 0..DIV-1 and resets to 0.
  - `tick` = 1 for the one cycle where the counter == DIV-1. With DIV=1, `tick` is high every cycle.
- **Counters**
  - `sample_cnt` is 4 bits and `bit_cnt` is 3 bits.
  - Both advance only on `tick` and wrap modulo their width.
- **FSM states** (transitions happen only on `tick`):
  - IDLE: if `rx_sync`==0, go to START with `sample_cnt`=0.
  - START:
    - `sample_cnt`++ each tick.
    - At `sample_cnt`==7 (mid start bit): if `rx_sync`==0, go to DATA with `sample_cnt`=0, `bit_cnt`=0.
    - Otherwise it is a false start: return to IDLE.
  - DATA:
    - `sample_cnt`++ each tick.
    - At `sample_cnt`==15: shift register ← {`rx_sync`, shift[7:1]} and `bit_cnt`++.
    - When `bit_cnt`==7 at that point, go to STOP.
  - STOP: at `sample_cnt`==15, sample `rx_sync`:
    - If 1: load `rx_data` ← shift register, set `rx_valid`=1, go to IDLE.
    - If 0: pulse `frame_err`, discard the byte (`rx_data`/`rx_valid` unchanged), go to WAIT_HIGH.
  - WAIT_HIGH: stay while `rx_sync`==0; go to IDLE on the first tick where `rx_sync`==1. This handles the line-break case.
- **Handshake**
  - `rx_valid` clears in the cycle after `rx_valid & rx_ready`, unless a new byte loads in the same cycle.
  - Simultaneous handshake and new-byte load: `rx_data` takes the new byte, `rx_valid` stays 1, no overrun.
  - New-byte load while `rx_valid`=1 and `rx_ready`=0: `rx_data` is overwritten, `rx_valid` stays 1, `rx_overrun` pulses for 1 cycle.
- `rx_busy` = (state != IDLE). It is registered with the state, so it has no combinational path.

## Timing
- Reset values:
  - `rx_data`=0x00, `rx_valid`=0, `rx_busy`=0, `frame_err`=0, `rx_overrun`=0.
  - state=IDLE, tick counter=0, `sample_cnt`=0, `bit_cnt`=0, synchronizer flops=1.
- Reset asserted mid-frame aborts immediately; the partial byte is lost.
- Bit period = 16*DIV clocks.
- Falling-edge detect uncertainty: 2 sync cycles plus up to DIV-1 cycles of tick phase.
- Sample point: 8 ticks after detect for the start bit, then every 16 ticks.
- `rx_valid` and `frame_err` go high on the clock edge of the STOP sample tick (`sample_cnt`==15).
- `rx_overrun` goes high on that same edge.
- With DIV=1, line start-edge to `rx_valid` = 2 + 8 + 8*16 + 16 = 154 clocks, ±1.
- A low glitch shorter than 8 ticks is rejected as a false start.
- The next start bit is accepted on the first tick after returning to IDLE, so back-to-back frames work with zero idle time.

## Test plan
- **Basic receive.** CLOCK_FREQ=16_000_000, BAUD_RATE=1_000_000 (DIV=1, 16 clk/bit). Drive frame 0xA5 with `rx_ready`=1 → `rx_data`=0xA5; `rx_valid` high for exactly 1 cycle, about 154 clocks after the start edge; `frame_err`=0.
- **Glitch rejection.** `rx_pin` low for 4 clocks, then high → no `rx_valid`; `rx_busy` high for ≤ 8 cycles, then FSM back in IDLE. A following 0x3C frame is received as 0x3C.
- **Framing error and recovery.** Frame 0x3C with stop bit driven low, line held low 40 bit times, then idle → `frame_err` 1-cycle pulse, `rx_valid` stays 0, `rx_busy` high until the line goes high. Next frame 0x81 → `rx_data`=0x81.
- **Overrun and back-to-back handshake.**
  - Back-to-back frames 0x11, 0x22 with `rx_ready`=0 → `rx_overrun` pulses once at the second load; `rx_data`=0x22; `rx_valid`=1.
  - Repeat with `rx_ready` pulsed on the exact cycle 0x22 loads → no overrun, `rx_valid` stays 1.
- **Reset mid-frame.** Assert `rst` during the 4th data bit of 0xF0 → all outputs reset immediately. Release reset, send 0x5A → `rx_data`=0x5A, no `frame_err`.
- **Loopback.** Connect `uart_transmitter.tx_pin` to `rx_pin`, default parameters (DIV=325). Send 0x00, 0xFF, 0x55 → each received intact, in order, with no errors.

Source files
------------

// File: rtl/uart_receiver_if.sv
// Receive-side byte handshake bundle.
//   rx_data  : last accepted byte (receiver -> consumer)
//   rx_valid : rx_data holds an unconsumed byte (receiver -> consumer)
//   rx_ready : consumer takes rx_data when rx_valid & rx_ready (consumer -> receiver)
// The master modport is the receiver side and the slave modport is the consumer side.
interface uart_receiver_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_receiver.sv
// UART receive stage: 8N1 frames, LSB first, 16x oversampling with mid-bit
// sampling, valid/ready byte delivery, framing-error and overrun pulses.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   rx_pin     asynchronous serial line input, idles high
//   rx_if      byte handshake (master side): rx_data, rx_valid, rx_ready
//   rx_busy    high whenever the receiver FSM is not idle
//   frame_err  one-cycle pulse when the stop bit is sampled low
//   rx_overrun one-cycle pulse when a new byte replaces an unconsumed one
module uart_receiver #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_pin,
  uart_receiver_if.master   rx_if,
  output logic              rx_busy,
  output logic              frame_err,
  output logic              rx_overrun
);

  localparam int DIV   = CLOCK_FREQ / (BAUD_RATE * 16);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  logic             sync_p0;
  logic             rx_sync;
  logic [CNT_W-1:0] div_cnt;
  logic             tick;
  logic [3:0]       sample_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_reg;
  state_t           state;

  // Two-flop synchronizer; resets to the idle line level so no false start
  // is seen coming out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      sync_p0 <= rx_pin;
      rx_sync <= sync_p0;
    end
  end

  // Free-running oversample divider; with DIV=1 the counter stays at 0 and
  // tick is high every cycle.
  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      sample_cnt     <= 4'd0;
      bit_cnt        <= 3'd0;
      shift_reg      <= 8'h00;
      rx_if.rx_data  <= 8'h00;
      rx_if.rx_valid <= 1'b0;
      rx_busy        <= 1'b0;
      frame_err      <= 1'b0;
      rx_overrun     <= 1'b0;
    end else begin
      frame_err  <= 1'b0;
      rx_overrun <= 1'b0;
      // A byte load below overrides this clear when both happen together.
      if (rx_if.rx_valid && rx_if.rx_ready) begin
        rx_if.rx_valid <= 1'b0;
      end

      if (tick) begin
        case (state)
          IDLE: begin
            if (!rx_sync) begin
              state      <= START;
              rx_busy    <= 1'b1;
              sample_cnt <= 4'd0;
            end
          end
          START: begin
            sample_cnt <= sample_cnt + 4'd1;
            // Mid start bit: a line that has gone high again was a glitch.
            if (sample_cnt == 4'd7) begin
              if (!rx_sync) begin
                state      <= DATA;
                sample_cnt <= 4'd0;
                bit_cnt    <= 3'd0;
              end else begin
                state   <= IDLE;
                rx_busy <= 1'b0;
              end
            end
          end
          DATA: begin
            // sample_cnt wraps 15 -> 0, so STOP starts its own bit at 0.
            sample_cnt <= sample_cnt + 4'd1;
            if (sample_cnt == 4'd15) begin
              shift_reg <= {rx_sync, shift_reg[7:1]};
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state <= STOP;
              end
            end
          end
          STOP: begin
            sample_cnt <= sample_cnt + 4'd1;
            if (sample_cnt == 4'd15) begin
              if (rx_sync) begin
                rx_if.rx_data  <= shift_reg;
                rx_if.rx_valid <= 1'b1;
                rx_overrun     <= rx_if.rx_valid && !rx_if.rx_ready;
                state          <= IDLE;
                rx_busy        <= 1'b0;
              end else begin
                frame_err <= 1'b1;
                state     <= WAIT_HIGH;
              end
            end
          end
          WAIT_HIGH: begin
            // Line break: hold off until the line returns to idle.
            if (rx_sync) begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end
          end
          default: begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
